matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer_if.sv | 32 +++
 rtl/matmul_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_sequencer_if.sv
// ---------------------------------------------------------------------------
// matmul_sequencer_if
// Streaming handshake bundle for the 3x3 matrix-multiply sequencer.
//   in_valid/in_data/in_ready     : element stream, A[0..8] then B[0..8]
//   out_valid/out_data/out_ready  : result stream C[0..8], row-major
//   out_last                      : marks C[8]
//   busy                          : sequencer is not idle
// Modport "slave" is the sequencer side, "master" is the producer/consumer.
// ---------------------------------------------------------------------------
interface matmul_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+2
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
// Loads two 3x3 unsigned matrices A and B element by element, computes
// C = A x B with a single multiply-accumulate unit (27 cycles), then streams
// the nine C elements out with a valid/ready handshake.
// Ports:
//   clk    : clock, rising-edge
//   rst_n  : asynchronous active-low reset, abandons any operation
//   bus    : matmul_sequencer_if.slave (element in, result out, busy)
// All interface outputs are registered; their next values are derived from
// the next state so they line up with the state register.
// ---------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+2
) (
  input  logic              clk,
  input  logic              rst_n,
  matmul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        load_cnt_q, load_cnt_d;
  logic [1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [3:0]        out_idx_q, out_idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;

  logic [DATA_W-1:0] a_q [0:8];
  logic [DATA_W-1:0] b_q [0:8];
  logic [ACC_W-1:0]  c_q [0:8];

  logic                in_beat_s, out_beat_s, mac_last_s, c_we_s;
  logic [4:0]          ld_cnt_s;
  logic [3:0]          ld_b_s;
  logic [3:0]          a_idx_s, b_idx_s, c_idx_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    mac_sum_s;

  assign in_beat_s  = bus.in_valid & in_ready_q;
  assign out_beat_s = out_valid_q & bus.out_ready;
  assign mac_last_s = (state_q == COMPUTE) && (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);

  // In IDLE the accepted element is always A[0]; B indices wrap modulo 16
  // so load counts 9..17 map onto 0..8 using only the low four bits.
  assign ld_cnt_s = (state_q == IDLE) ? 5'd0 : load_cnt_q;
  assign ld_b_s   = ld_cnt_s[3:0] - 4'd9;

  assign a_idx_s   = ({2'b00, i_q} * 4'd3) + {2'b00, k_q};
  assign b_idx_s   = ({2'b00, k_q} * 4'd3) + {2'b00, j_q};
  assign c_idx_s   = ({2'b00, i_q} * 4'd3) + {2'b00, j_q};
  assign prod_s    = a_q[a_idx_s] * b_q[b_idx_s];
  assign mac_sum_s = ((k_q == 2'd0) ? {ACC_W{1'b0}} : acc_q) + ACC_W'(prod_s);
  assign c_we_s    = (state_q == COMPUTE) && (k_q == 2'd2);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_beat_s) state_d = LOAD;
        else           state_d = IDLE;
      end
      LOAD: begin
        if (in_beat_s && (load_cnt_q == 5'd17)) state_d = COMPUTE;
        else                                    state_d = LOAD;
      end
      COMPUTE: begin
        if (mac_last_s) state_d = DRAIN;
        else            state_d = COMPUTE;
      end
      DRAIN: begin
        if (out_beat_s && (out_idx_q == 4'd8)) state_d = IDLE;
        else                                   state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered output next values, aligned with the next state.
  always_comb begin
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && (out_idx_d == 4'd8);
    busy_d      = (state_d != IDLE);
    if (state_d == DRAIN) begin
      out_data_d = c_q[out_idx_d];
    end else begin
      out_data_d = {ACC_W{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= {ACC_W{1'b0}};
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  // Counter and accumulator next values.
  always_comb begin
    load_cnt_d = load_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    out_idx_d  = out_idx_q;
    acc_d      = acc_q;
    case (state_q)
      IDLE: begin
        if (in_beat_s) load_cnt_d = 5'd1;
        else           load_cnt_d = 5'd0;
        i_d       = 2'd0;
        j_d       = 2'd0;
        k_d       = 2'd0;
        out_idx_d = 4'd0;
      end
      LOAD: begin
        if (in_beat_s) begin
          if (load_cnt_q == 5'd17) load_cnt_d = 5'd0;
          else                     load_cnt_d = load_cnt_q + 5'd1;
        end else begin
          load_cnt_d = load_cnt_q;
        end
        i_d   = 2'd0;
        j_d   = 2'd0;
        k_d   = 2'd0;
        acc_d = {ACC_W{1'b0}};
      end
      COMPUTE: begin
        acc_d     = mac_sum_s;
        out_idx_d = 4'd0;
        // k innermost, then j (column), then i (row).
        if (k_q == 2'd2) begin
          k_d = 2'd0;
          if (j_q == 2'd2) begin
            j_d = 2'd0;
            if (i_q == 2'd2) i_d = 2'd0;
            else             i_d = i_q + 2'd1;
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DRAIN: begin
        if (out_beat_s) begin
          if (out_idx_q == 4'd8) out_idx_d = 4'd0;
          else                   out_idx_d = out_idx_q + 4'd1;
        end else begin
          out_idx_d = out_idx_q;
        end
      end
      default: begin
        load_cnt_d = 5'd0;
        i_d        = 2'd0;
        j_d        = 2'd0;
        k_d        = 2'd0;
        out_idx_d  = 4'd0;
        acc_d      = {ACC_W{1'b0}};
      end
    endcase
  end

  // Counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= 5'd0;
      i_q        <= 2'd0;
      j_q        <= 2'd0;
      k_q        <= 2'd0;
      out_idx_q  <= 4'd0;
      acc_q      <= {ACC_W{1'b0}};
    end else begin
      load_cnt_q <= load_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      out_idx_q  <= out_idx_d;
      acc_q      <= acc_d;
    end
  end

  // Matrix storage; every element is rewritten before it is read, so no reset.
  always_ff @(posedge clk) begin
    if (in_beat_s) begin
      if (ld_cnt_s < 5'd9) a_q[ld_cnt_s[3:0]] <= bus.in_data;
      else                 b_q[ld_b_s]        <= bus.in_data;
    end
    if (c_we_s) c_q[c_idx_s] <= mac_sum_s;
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_run = 0;
  int   n_fail = 0;

  logic [7:0]       stim  [0:17];
  logic [ACC_W-1:0] exp_c [0:8];

  // results gathered by the driver tasks
  logic [ACC_W-1:0] got_data [0:8];
  logic             got_last [0:8];
  int n_got, stall_bad, first_ov_cyc, t_last, first_wait, ready_drop;
  bit recv_timeout, send_timeout, saw_ov;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus_if ();

  matmul_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic set_identity_ramp();
    for (int n = 0; n < 9; n++) begin
      stim[n]     = ((n == 0) || (n == 4) || (n == 8)) ? 8'd1 : 8'd0;
      stim[9 + n] = 8'(n + 1);
      exp_c[n]    = 18'(n + 1);
    end
  endtask

  task automatic set_ramp_rev();
    for (int n = 0; n < 9; n++) begin
      stim[n]     = 8'(n + 1);
      stim[9 + n] = 8'(9 - n);
    end
    exp_c = '{18'd30, 18'd24, 18'd18, 18'd84, 18'd69, 18'd54, 18'd138, 18'd114, 18'd90};
  endtask

  // Streams stim[0..17] with 'gap' idle cycles between elements.
  task automatic send_all(input int gap);
    int guard;
    ready_drop = 0; saw_ov = 1'b0; send_timeout = 1'b0; first_wait = 0;
    for (int e = 0; e < 18; e++) begin
      @(negedge clk);
      if (bus_if.out_valid) saw_ov = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = stim[e];
      guard = 0;
      while (!bus_if.in_ready && guard < 40) begin
        @(negedge clk);
        if (bus_if.out_valid) saw_ov = 1'b1;
        guard++;
      end
      if (e == 0) first_wait = guard;
      if (guard >= 40) send_timeout = 1'b1;
      t_last = cyc;
      if (e < 17) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bus_if.in_valid = 1'b0;
          bus_if.in_data  = 8'd0;
          if (!bus_if.in_ready) ready_drop++;
          if (bus_if.out_valid) saw_ov = 1'b1;
        end
      end
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'd0;
  endtask

  // Collects nine results; mode 1 drives out_ready 1,0,0,1 repeating.
  task automatic recv_all(input int mode);
    int budget, p;
    logic stalled;
    logic [ACC_W-1:0] held;
    n_got = 0; stall_bad = 0; first_ov_cyc = -1; recv_timeout = 1'b0;
    stalled = 1'b0; held = '0; budget = 0; p = 0;
    while (n_got < 9 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (stalled && (!bus_if.out_valid || bus_if.out_data !== held)) stall_bad++;
      if (bus_if.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (mode == 1) bus_if.out_ready = ((p % 4) == 0) || ((p % 4) == 3);
      else           bus_if.out_ready = 1'b1;
      p++;
      stalled = 1'b0;
      if (bus_if.out_valid) begin
        if (bus_if.out_ready) begin
          got_data[n_got] = bus_if.out_data;
          got_last[n_got] = bus_if.out_last;
          n_got++;
        end else begin
          stalled = 1'b1;
          held    = bus_if.out_data;
        end
      end
    end
    if (n_got < 9) recv_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_run++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus_if.in_ready); end
    n_run++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    n_run++; if (bus_if.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", bus_if.out_last); end
    n_run++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    n_run++; if (bus_if.out_data !== 18'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", bus_if.out_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_run++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus_if.in_ready); end
    n_run++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", bus_if.busy); end
  endtask

  task automatic test_identity();
    set_identity_ramp();
    send_all(0);
    recv_all(0);
    n_run++; if (recv_timeout) begin n_fail++; $display("FAIL ident_timeout: got %0d results want 9", n_got); end
    n_run++; if (first_ov_cyc - t_last !== 28) begin n_fail++; $display("FAIL ident_latency: got %0d want 28", first_ov_cyc - t_last); end
    for (int n = 0; n < 9; n++) begin
      n_run++; if (got_data[n] !== exp_c[n]) begin n_fail++; $display("FAIL ident_data[%0d]: got %0d want %0d", n, got_data[n], exp_c[n]); end
      n_run++; if (got_last[n] !== (n == 8)) begin n_fail++; $display("FAIL ident_last[%0d]: got %b want %b", n, got_last[n], (n == 8)); end
    end
    n_run++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL ident_busy_drain: got %b want 1", bus_if.busy); end
    @(negedge clk);
    n_run++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL ident_idle_out_valid: got %b want 0", bus_if.out_valid); end
    n_run++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL ident_idle_in_ready: got %b want 1", bus_if.in_ready); end
    n_run++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL ident_idle_busy: got %b want 0", bus_if.busy); end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 18; n++) stim[n] = 8'd255;
    send_all(0);
    recv_all(0);
    n_run++; if (recv_timeout) begin n_fail++; $display("FAIL sat_timeout: got %0d results want 9", n_got); end
    for (int n = 0; n < 9; n++) begin
      n_run++; if (got_data[n] !== 18'd195075) begin n_fail++; $display("FAIL sat_data[%0d]: got %0d want 195075", n, got_data[n]); end
    end
  endtask

  task automatic test_stall();
    set_ramp_rev();
    send_all(0);
    recv_all(1);
    n_run++; if (recv_timeout) begin n_fail++; $display("FAIL stall_timeout: got %0d results want 9", n_got); end
    n_run++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
    for (int n = 0; n < 9; n++) begin
      n_run++; if (got_data[n] !== exp_c[n]) begin n_fail++; $display("FAIL stall_data[%0d]: got %0d want %0d", n, got_data[n], exp_c[n]); end
      n_run++; if (got_last[n] !== (n == 8)) begin n_fail++; $display("FAIL stall_last[%0d]: got %b want %b", n, got_last[n], (n == 8)); end
    end
  endtask

  task automatic test_gaps();
    set_ramp_rev();
    send_all(3);
    n_run++; if (ready_drop !== 0) begin n_fail++; $display("FAIL gap_in_ready: got %0d low cycles want 0", ready_drop); end
    n_run++; if (send_timeout) begin n_fail++; $display("FAIL gap_send_timeout: got 1 want 0"); end
    recv_all(0);
    for (int n = 0; n < 9; n++) begin
      n_run++; if (got_data[n] !== exp_c[n]) begin n_fail++; $display("FAIL gap_data[%0d]: got %0d want %0d", n, got_data[n], exp_c[n]); end
    end
  endtask

  task automatic test_reset_mid();
    set_identity_ramp();
    for (int n = 9; n < 18; n++) stim[n] = 8'd7;
    send_all(0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_run++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus_if.busy); end
    n_run++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", bus_if.in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_run++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus_if.out_valid); end
    set_identity_ramp();
    send_all(0);
    n_run++; if (saw_ov !== 1'b0) begin n_fail++; $display("FAIL midrst_early_output: got 1 want 0"); end
    recv_all(0);
    n_run++; if (recv_timeout) begin n_fail++; $display("FAIL midrst_timeout: got %0d results want 9", n_got); end
    for (int n = 0; n < 9; n++) begin
      n_run++; if (got_data[n] !== exp_c[n]) begin n_fail++; $display("FAIL midrst_data[%0d]: got %0d want %0d", n, got_data[n], exp_c[n]); end
    end
  endtask

  task automatic test_back_to_back();
    set_identity_ramp();
    send_all(0);
    recv_all(0);
    for (int n = 0; n < 9; n++) begin
      n_run++; if (got_data[n] !== 18'(n + 1)) begin n_fail++; $display("FAIL b2b_first_data[%0d]: got %0d want %0d", n, got_data[n], n + 1); end
    end
    set_ramp_rev();
    send_all(0);
    n_run++; if (first_wait !== 0) begin n_fail++; $display("FAIL b2b_accept: got %0d wait cycles want 0", first_wait); end
    recv_all(0);
    n_run++; if (recv_timeout) begin n_fail++; $display("FAIL b2b_timeout: got %0d results want 9", n_got); end
    for (int n = 0; n < 9; n++) begin
      n_run++; if (got_data[n] !== exp_c[n]) begin n_fail++; $display("FAIL b2b_second_data[%0d]: got %0d want %0d", n, got_data[n], exp_c[n]); end
    end
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'd0;
    bus_if.out_ready = 1'b1;
    test_reset();
    test_identity();
    test_saturate();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
